led_left_ws2812_tx: RTL and testbench

Downstream consumer of the left-edge zone averager in the ambient-light (Pan) pipeline. Captures the per-frame stream of 24-bit left-edge zone colours, snapshots the set at frame end, and serialises it onto a single WS2812-class LED data line, one LED per zone. Runs in the 148.5 MHz pixel clock domain; its `led_dout` pin drives the left LED strip directly.

---
 rtl/led_left_ws2812_tx.sv | 137 +++++++++++++
 tb/tb_led_left_ws2812_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_left_ws2812_tx.sv
// rtl/led_left_ws2812_tx.sv - left-edge zone colour capture and WS2812 serial transmitter
module led_left_ws2812_tx #(
  parameter int ZONES = 45,
  parameter int T_BIT = 186,
  parameter int T0H   = 59,
  parameter int T1H   = 119,
  parameter int T_RES = 44550
) (
  input  logic        clkn,
  input  logic        reset,
  input  logic        vs,
  input  logic        din_valid,
  input  logic [23:0] din,
  output logic        led_dout,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_drop
);

  localparam int ZI_W  = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int WP_W  = $clog2(ZONES + 1);
  localparam int CNT_W = ($clog2(T_BIT) > 8) ? $clog2(T_BIT) : 8;
  localparam int LAT_W = ($clog2(T_RES) > 16) ? $clog2(T_RES) : 16;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(T_RES - 1);
  localparam logic [ZI_W-1:0]  ZI_LAST  = ZI_W'(ZONES - 1);
  localparam logic [WP_W-1:0]  WP_FULL  = WP_W'(ZONES);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t            state;
  logic              vs_q;
  logic              frame_end;
  logic [WP_W-1:0]   wr_ptr;
  logic [23:0]       cap [ZONES];
  logic [23:0]       tx  [ZONES];
  logic [ZI_W-1:0]   zone_idx;
  logic [4:0]        bit_idx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [23:0]       cur_grb;
  logic              cur_bit;

  assign frame_end = vs & ~vs_q;

  always_comb begin
    cur_grb = {tx[zone_idx][15:8], tx[zone_idx][23:16], tx[zone_idx][7:0]};
    cur_bit = cur_grb[5'd23 - bit_idx];
    cnt_nxt = bit_cnt + 1'b1;
  end

  // A strobe coinciding with the vs edge is dropped: the write needs vs low,
  // the edge needs vs high, so the pointer clear never races a write.
  always_ff @(negedge clkn) begin
    vs_q <= vs;
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < ZONES; i++) cap[i] <= '0;
    end else if (frame_end) begin
      wr_ptr <= '0;
    end else if (din_valid && !vs && (wr_ptr < WP_FULL)) begin
      cap[wr_ptr[ZI_W-1:0]] <= din;
      wr_ptr                <= wr_ptr + 1'b1;
    end
  end

  always_ff @(negedge clkn) begin
    if (reset) begin
      state      <= IDLE;
      led_dout   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      zone_idx   <= '0;
      bit_idx    <= '0;
      bit_cnt    <= '0;
      lat_cnt    <= '0;
      for (int i = 0; i < ZONES; i++) tx[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_drop <= frame_end && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_end) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          for (int i = 0; i < ZONES; i++) tx[i] <= cap[i];
          zone_idx <= '0;
          bit_idx  <= '0;
          bit_cnt  <= '0;
          led_dout <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          // led_dout is registered, so it is computed from the next bit_cnt
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            led_dout <= 1'b1;
            if (bit_idx == 5'd23) begin
              bit_idx <= '0;
              if (zone_idx == ZI_LAST) begin
                state    <= LATCH;
                lat_cnt  <= '0;
                led_dout <= 1'b0;
              end else begin
                zone_idx <= zone_idx + 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt  <= cnt_nxt;
            led_dout <= cnt_nxt < (cur_bit ? T1H_C : T0H_C);
          end
        end
        LATCH: begin
          if (lat_cnt == LAT_LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_left_ws2812_tx.sv
// tb/tb_led_left_ws2812_tx.sv - self-checking bench for led_left_ws2812_tx
module tb_led_left_ws2812_tx;

  localparam int ZONES = 45;
  localparam int T_BIT = 6;
  localparam int T0H   = 2;
  localparam int T1H   = 4;
  localparam int T_RES = 40;

  logic        clkn = 1'b0;
  logic        reset;
  logic        vs;
  logic        din_valid;
  logic [23:0] din;
  logic        led_dout;
  logic        busy;
  logic        frame_done;
  logic        frame_drop;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [23:0] model_cap [ZONES];
  int          model_wr;
  logic [23:0] exp_grb [ZONES];
  logic [23:0] dec [ZONES];

  led_left_ws2812_tx #(
    .ZONES(ZONES), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RES(T_RES)
  ) dut (
    .clkn(clkn), .reset(reset), .vs(vs), .din_valid(din_valid), .din(din),
    .led_dout(led_dout), .busy(busy), .frame_done(frame_done), .frame_drop(frame_drop)
  );

  always #5 clkn = ~clkn;

  function automatic logic [23:0] to_grb(input logic [23:0] c);
    return {c[15:8], c[23:16], c[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ZONES; i++) model_cap[i] = '0;
    model_wr = 0;
  endtask

  task automatic open_frame();
    @(posedge clkn);
    vs = 1'b0;
  endtask

  task automatic strobe(input logic [23:0] d);
    @(posedge clkn);
    din_valid = 1'b1;
    din       = d;
    if (!vs && model_wr < ZONES) begin
      model_cap[model_wr] = d;
      model_wr++;
    end
    @(posedge clkn);
    din_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clkn);
  endtask

  // A strobe issued together with the vs rise is ignored, so the model does not store it.
  task automatic frame_end(input logic with_strobe, input logic [23:0] d);
    @(posedge clkn);
    vs        = 1'b1;
    din_valid = with_strobe;
    din       = d;
    model_wr  = 0;
    for (int i = 0; i < ZONES; i++) exp_grb[i] = to_grb(model_cap[i]);
  endtask

  // Decodes one full transmission whose vs edge was driven on the previous posedge.
  task automatic run_frame(input string tag);
    int          bad;
    int          hi;
    logic        gap;
    logic        first_led;
    logic [23:0] w;
    bad = 0;
    @(posedge clkn);
    din_valid = 1'b0;
    check({tag, "_load_busy"}, 32'(busy), 32'd1);
    check({tag, "_load_led"}, 32'(led_dout), 32'd0);
    first_led = 1'b0;
    for (int z = 0; z < ZONES; z++) begin
      w = '0;
      for (int b = 0; b < 24; b++) begin
        hi  = 0;
        gap = 1'b0;
        for (int c = 0; c < T_BIT; c++) begin
          @(posedge clkn);
          if (z == 0 && b == 0 && c == 0) first_led = led_dout;
          if (led_dout === 1'b1) begin
            if (gap) bad++;
            hi++;
          end else begin
            gap = 1'b1;
          end
          if (busy !== 1'b1 || frame_done !== 1'b0) bad++;
        end
        if (hi != T0H && hi != T1H) bad++;
        w = {w[22:0], (hi == T1H)};
      end
      dec[z] = w;
    end
    for (int c = 0; c < T_RES; c++) begin
      @(posedge clkn);
      if (led_dout !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1) bad++;
    end
    @(posedge clkn);
    check({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    @(posedge clkn);
    check({tag, "_done_single"}, 32'(frame_done), 32'd0);
    check({tag, "_first_bit_high"}, 32'(first_led), 32'd1);
    check({tag, "_bad_periods"}, 32'(bad), 32'd0);
    for (int z = 0; z < ZONES; z++)
      check($sformatf("%s_zone%0d", tag, z), 32'(dec[z]), 32'(exp_grb[z]));
  endtask

  initial begin
    int bad;
    reset     = 1'b1;
    vs        = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      @(posedge clkn);
      vs = (i == 1);
      if (i > 0) begin
        check("rst_led", 32'(led_dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_drop", 32'(frame_drop), 32'd0);
      end
    end
    @(posedge clkn);
    reset = 1'b0;
    bad   = 0;
    repeat (5) begin
      @(posedge clkn);
      if (led_dout !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || frame_drop !== 1'b0) bad++;
    end
    check("post_rst_quiet", 32'(bad), 32'd0);

    open_frame();
    for (int k = 0; k < ZONES; k++) strobe({8'(k), 8'h00, 8'hFF});
    frame_end(1'b0, 24'h0);
    run_frame("single");
    check("single_zone7_const", 32'(dec[7]), 32'h0007FF);

    open_frame();
    for (int k = 0; k < 50; k++) strobe((k < 45) ? 24'h123456 : 24'hFFFFFF);
    frame_end(1'b0, 24'h0);
    run_frame("overlen");
    check("overlen_zone44_const", 32'(dec[44]), 32'h341256);

    open_frame();
    for (int k = 0; k < ZONES; k++) strobe(24'h0000FF);
    frame_end(1'b0, 24'h0);
    run_frame("short_a");
    open_frame();
    for (int k = 0; k < 10; k++) strobe(24'hFF0000);
    frame_end(1'b1, 24'hABCDEF);
    run_frame("short_b");
    check("short_zone9_const", 32'(dec[9]), 32'h00FF00);
    check("short_zone10_edge_strobe", 32'(dec[10]), 32'h0000FF);

    open_frame();
    for (int k = 0; k < ZONES; k++) strobe(24'($urandom));
    frame_end(1'b0, 24'h0);
    fork
      run_frame("drop_a");
      begin
        repeat (50) @(posedge clkn);
        vs = 1'b0;
        for (int k = 0; k < ZONES; k++) strobe(24'($urandom));
        @(posedge clkn);
        vs       = 1'b1;
        model_wr = 0;
        @(posedge clkn);
        check("drop_pulse", 32'(frame_drop), 32'd1);
        check("drop_busy", 32'(busy), 32'd1);
        @(posedge clkn);
        check("drop_single", 32'(frame_drop), 32'd0);
      end
    join
    open_frame();
    repeat (3) @(posedge clkn);
    frame_end(1'b0, 24'h0);
    run_frame("drop_b");

    open_frame();
    for (int k = 0; k < ZONES; k++) strobe(24'($urandom));
    frame_end(1'b0, 24'h0);
    @(posedge clkn);
    din_valid = 1'b0;
    repeat (1 + 100 * T_BIT) @(posedge clkn);
    check("midrst_pre_led", 32'(led_dout), 32'd1);
    reset = 1'b1;
    @(posedge clkn);
    check("midrst_led", 32'(led_dout), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    model_reset();
    bad = 0;
    repeat (T_RES + 4 * T_BIT) begin
      @(posedge clkn);
      if (frame_done !== 1'b0 || busy !== 1'b0 || led_dout !== 1'b0) bad++;
    end
    check("midrst_no_done", 32'(bad), 32'd0);
    open_frame();
    for (int k = 0; k < 10; k++) strobe(24'($urandom));
    frame_end(1'b0, 24'h0);
    run_frame("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
